pc_ras_unit: RTL and testbench

Parametrised program-counter unit for the single-cycle/pipelined CPU datapath. It generalises the plain PC register with configurable address width, reset vector and increment, and adds a stall input, a registered redirect indicator and a circular return-address stack (RAS) for call/return. It sits at the head of the fetch stage: `addr` drives instruction memory, and redirect requests arrive from EX.

---
 rtl/pc_ras_unit.sv | 127 ++++++++++++
 tb/tb_pc_ras_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pc_ras_unit.sv
// Program counter for the fetch stage with branch/jump/return redirects,
// stall/halt control and a circular return-address stack.
module pc_ras_unit #(
    parameter int ADDR_W     = 16,
    parameter int RAS_DEPTH  = 4,
    parameter int RESET_ADDR = 0,
    parameter int INCR       = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_hlt,
    input  logic                         i_stall,
    input  logic                         i_br,
    input  logic [ADDR_W-1:0]            i_br_target,
    input  logic                         i_jump,
    input  logic [ADDR_W-1:0]            i_jump_target,
    input  logic                         i_call,
    input  logic [ADDR_W-1:0]            i_link_addr,
    input  logic                         i_ret,
    input  logic [ADDR_W-1:0]            i_ret_target,
    output logic [ADDR_W-1:0]            o_addr,
    output logic [ADDR_W-1:0]            o_addr_plus,
    output logic                         o_redirect,
    output logic [$clog2(RAS_DEPTH):0]   o_ras_count,
    output logic                         o_ras_empty,
    output logic                         o_ras_full,
    output logic                         o_ras_ovf
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] INCR_V  = ADDR_W'(INCR);
    localparam logic [ADDR_W-1:0] RESET_V = ADDR_W'(RESET_ADDR);
    localparam logic [CNT_W-1:0]  DEPTH_V = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] r_addr;
    logic              r_redirect;
    logic [CNT_W-1:0]  r_cnt;
    logic [PTR_W-1:0]  r_top;
    logic              r_ovf;
    logic [ADDR_W-1:0] r_ras [RAS_DEPTH];

    logic [ADDR_W-1:0] w_addr_plus;
    logic [ADDR_W-1:0] w_addr_next;
    logic              w_redirect_next;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic              w_full;
    logic [PTR_W-1:0]  w_top_inc;

    assign w_addr_plus = r_addr + INCR_V;
    assign w_empty     = (r_cnt == '0);
    assign w_full      = (r_cnt == DEPTH_V);
    assign w_top_inc   = r_top + PTR_W'(1);

    // Redirect priority below halt: br > jump(+call) > ret > stall > sequential.
    always_comb begin
        w_addr_next     = w_addr_plus;
        w_redirect_next = 1'b0;
        w_push          = 1'b0;
        w_pop           = 1'b0;
        if (i_br) begin
            w_addr_next     = i_br_target;
            w_redirect_next = 1'b1;
        end else if (i_jump) begin
            w_addr_next     = i_jump_target;
            w_redirect_next = 1'b1;
            w_push          = i_call;
        end else if (i_ret) begin
            w_redirect_next = 1'b1;
            if (w_empty) begin
                w_addr_next = i_ret_target;
            end else begin
                w_addr_next = r_ras[r_top];
                w_pop       = 1'b1;
            end
        end else if (i_stall) begin
            w_addr_next = r_addr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr     <= RESET_V;
            r_redirect <= 1'b0;
            r_cnt      <= '0;
            r_top      <= '0;
            r_ovf      <= 1'b0;
        end else if (!i_hlt) begin
            r_addr     <= w_addr_next;
            r_redirect <= w_redirect_next;
            if (w_push) begin
                r_top <= w_top_inc;
                // A full stack keeps its count; the wrapped top overwrites the oldest entry.
                if (w_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else if (w_pop) begin
                r_top <= r_top - PTR_W'(1);
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end

    // Stack storage carries no reset; only count and pointer define validity.
    generate
        for (genvar gi = 0; gi < RAS_DEPTH; gi++) begin : g_ras
            always_ff @(posedge i_clk) begin
                if (!i_rst && !i_hlt && w_push && (w_top_inc == PTR_W'(gi))) begin
                    r_ras[gi] <= i_link_addr;
                end
            end
        end
    endgenerate

    assign o_addr      = r_addr;
    assign o_addr_plus = w_addr_plus;
    assign o_redirect  = r_redirect;
    assign o_ras_count = r_cnt;
    assign o_ras_empty = w_empty;
    assign o_ras_full  = w_full;
    assign o_ras_ovf   = r_ovf;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed bench for pc_ras_unit: each stimulus cycle queues hand-computed
// expected state; a negedge monitor pops and compares.
module tb_pc_ras_unit;

    logic        clk = 1'b0;
    logic        rst, hlt, stall, br, jump, call, ret;
    logic [15:0] br_target, jump_target, link_addr, ret_target;
    logic [15:0] addr, addr_plus;
    logic        redirect, ras_empty, ras_full, ras_ovf;
    logic [2:0]  ras_count;

    typedef struct {
        logic [15:0] a;
        logic        r;
        logic [2:0]  c;
        logic        o;
        string       nm;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    pc_ras_unit dut (
        .i_clk(clk), .i_rst(rst), .i_hlt(hlt), .i_stall(stall),
        .i_br(br), .i_br_target(br_target),
        .i_jump(jump), .i_jump_target(jump_target),
        .i_call(call), .i_link_addr(link_addr),
        .i_ret(ret), .i_ret_target(ret_target),
        .o_addr(addr), .o_addr_plus(addr_plus), .o_redirect(redirect),
        .o_ras_count(ras_count), .o_ras_empty(ras_empty),
        .o_ras_full(ras_full), .o_ras_ovf(ras_ovf)
    );

    task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s.%s got %h expected %h", nm, fld, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.nm, "addr",      addr,                 e.a);
            chk(e.nm, "addr_plus", addr_plus,            e.a + 16'd1);
            chk(e.nm, "redirect",  {15'd0, redirect},    {15'd0, e.r});
            chk(e.nm, "ras_count", {13'd0, ras_count},   {13'd0, e.c});
            chk(e.nm, "ras_empty", {15'd0, ras_empty},   {15'd0, (e.c == 3'd0)});
            chk(e.nm, "ras_full",  {15'd0, ras_full},    {15'd0, (e.c == 3'd4)});
            chk(e.nm, "ras_ovf",   {15'd0, ras_ovf},     {15'd0, e.o});
            $display("[TB] %-10s addr=%h redir=%b cnt=%0d ovf=%b", e.nm, addr, redirect, ras_count, ras_ovf);
        end
    end

    task automatic idle();
        rst = 0; hlt = 0; stall = 0; br = 0; jump = 0; call = 0; ret = 0;
    endtask

    // Apply current inputs for one edge and queue the state expected after it.
    task automatic tick(input logic [15:0] a, input logic r, input logic [2:0] c, input logic o, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        e.a = a; e.r = r; e.c = c; e.o = o; e.nm = nm;
        sb.push_back(e);
    endtask

    initial begin
        idle();
        br_target = 0; jump_target = 0; link_addr = 0; ret_target = 0;
        @(negedge clk);

        rst = 1;
        tick(16'h0000, 0, 0, 0, "rst1");
        tick(16'h0000, 0, 0, 0, "rst2");
        idle();
        tick(16'h0001, 0, 0, 0, "seq1");
        tick(16'h0002, 0, 0, 0, "seq2");
        tick(16'h0003, 0, 0, 0, "seq3");

        br = 1; br_target = 16'hFFFE;
        tick(16'hFFFE, 1, 0, 0, "br_fffe");
        idle();
        tick(16'hFFFF, 0, 0, 0, "wrap1");
        tick(16'h0000, 0, 0, 0, "wrap2");
        tick(16'h0001, 0, 0, 0, "wrap3");
        stall = 1;
        tick(16'h0001, 0, 0, 0, "stall1");
        tick(16'h0001, 0, 0, 0, "stall2");
        tick(16'h0001, 0, 0, 0, "stall3");
        br = 1; br_target = 16'h0200;
        tick(16'h0200, 1, 0, 0, "br_stall");
        idle();
        tick(16'h0201, 0, 0, 0, "seq4");

        jump = 1; call = 1; jump_target = 16'h0100; link_addr = 16'h0011;
        tick(16'h0100, 1, 1, 0, "call");
        idle(); ret = 1; ret_target = 16'h0042;
        tick(16'h0011, 1, 0, 0, "ret");
        tick(16'h0042, 1, 0, 0, "ret_empty");
        idle();
        tick(16'h0043, 0, 0, 0, "seq5");

        jump = 1; call = 1; jump_target = 16'h0300;
        link_addr = 16'h000A; tick(16'h0300, 1, 1, 0, "push_a");
        link_addr = 16'h000B; tick(16'h0300, 1, 2, 0, "push_b");
        link_addr = 16'h000C; tick(16'h0300, 1, 3, 0, "push_c");
        link_addr = 16'h000D; tick(16'h0300, 1, 4, 0, "push_d");
        link_addr = 16'h000E; tick(16'h0300, 1, 4, 1, "push_e");
        idle(); ret = 1; ret_target = 16'h0055;
        tick(16'h000E, 1, 3, 1, "pop_e");
        tick(16'h000D, 1, 2, 1, "pop_d");
        tick(16'h000C, 1, 1, 1, "pop_c");
        tick(16'h000B, 1, 0, 1, "pop_b");
        tick(16'h0055, 1, 0, 1, "pop_empty");

        idle(); jump = 1; call = 1; jump_target = 16'h0400; link_addr = 16'h0777;
        tick(16'h0400, 1, 1, 1, "push_777");
        br = 1; ret = 1; br_target = 16'h0500; jump_target = 16'h0600; link_addr = 16'h0888;
        tick(16'h0500, 1, 1, 1, "prio_br");
        idle(); jump = 1; ret = 1; jump_target = 16'h0700;
        tick(16'h0700, 1, 1, 1, "prio_jmp");
        idle(); ret = 1;
        tick(16'h0777, 1, 0, 1, "pop_777");

        idle(); jump = 1; call = 1; jump_target = 16'h0800;
        link_addr = 16'h0011; tick(16'h0800, 1, 1, 1, "push_h1");
        link_addr = 16'h0012; tick(16'h0800, 1, 2, 1, "push_h2");
        link_addr = 16'h0013; tick(16'h0800, 1, 3, 1, "push_h3");
        idle(); hlt = 1; br = 1; br_target = 16'h0900;
        tick(16'h0800, 1, 3, 1, "hlt_br");
        br = 0; ret = 1;
        tick(16'h0800, 1, 3, 1, "hlt_ret");
        idle();
        tick(16'h0801, 0, 3, 1, "unhalt");
        rst = 1; hlt = 1;
        tick(16'h0000, 0, 0, 0, "rst_hlt");
        idle();
        tick(16'h0001, 0, 0, 0, "seq6");
        ret = 1; ret_target = 16'h0099;
        tick(16'h0099, 1, 0, 0, "ret_rst");
        idle();

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        #6;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL drain pending=%0d expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
